// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between the CPU, the hardware requesters,
// the write arbiter and the regfile write port.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic                      cpu_we;
  logic [ADDR_W-1:0]         cpu_rd;
  logic [DATA_W-1:0]         cpu_data;

  logic [NUM_REQ-1:0]        hw_valid;
  logic [NUM_REQ-1:0]        hw_ready;
  logic [NUM_REQ*ADDR_W-1:0] hw_rd;
  logic [NUM_REQ*DATA_W-1:0] hw_data;

  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_rd;
  logic [DATA_W-1:0]         rf_data;

  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        pending;
  logic                      cpu_collide;

  modport master (
    output cpu_we, cpu_rd, cpu_data, hw_valid, hw_rd, hw_data,
    input  hw_ready, rf_we, rf_rd, rf_data, grant, pending, cpu_collide
  );

  modport slave (
    input  cpu_we, cpu_rd, cpu_data, hw_valid, hw_rd, hw_data,
    output hw_ready, rf_we, rf_rd, rf_data, grant, pending, cpu_collide
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the CPU (always wins) and NUM_REQ
// hardware requesters, each buffered in a 1-deep slot drained round-robin.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t        slot_state [NUM_REQ];
  logic [ADDR_W-1:0]  slot_rd    [NUM_REQ];
  logic [DATA_W-1:0]  slot_data  [NUM_REQ];
  logic [PTR_W-1:0]   rr_ptr;
  logic               collide_q;

  logic [NUM_REQ-1:0] full_vec;
  logic [NUM_REQ-1:0] grant_c;
  logic               drain;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   sel;
  logic [ADDR_W-1:0]  win_rd;
  logic [DATA_W-1:0]  win_data;
  logic               collide_hit;
  int                 idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      full_vec[i] = (slot_state[i] == FULL);
    end
  end

  // Round-robin search starting at rr_ptr; a CPU write suppresses any drain.
  always_comb begin
    drain    = 1'b0;
    grant_c  = '0;
    next_ptr = rr_ptr;
    sel      = '0;
    win_rd   = '0;
    win_data = '0;
    idx      = 0;
    if (!bus.cpu_we) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        sel = PTR_W'(idx);
        if (!drain && full_vec[sel]) begin
          drain         = 1'b1;
          grant_c[sel]  = 1'b1;
          win_rd        = slot_rd[sel];
          win_data      = slot_data[sel];
          next_ptr      = PTR_W'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    collide_hit = 1'b0;
    if (bus.cpu_we && (bus.cpu_rd != '0)) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (full_vec[i] && (slot_rd[i] == bus.cpu_rd)) begin
          collide_hit = 1'b1;
        end
      end
    end
  end

  // Slot FSMs, round-robin pointer and sticky collision flag.
  // Requests to r0 complete the handshake but never occupy the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_state[i] <= EMPTY;
        slot_rd[i]    <= '0;
        slot_data[i]  <= '0;
      end
      rr_ptr    <= '0;
      collide_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case (slot_state[i])
          EMPTY: begin
            if (bus.hw_valid[i] && (bus.hw_rd[i*ADDR_W +: ADDR_W] != '0)) begin
              slot_state[i] <= FULL;
              slot_rd[i]    <= bus.hw_rd[i*ADDR_W +: ADDR_W];
              slot_data[i]  <= bus.hw_data[i*DATA_W +: DATA_W];
            end
          end
          FULL: begin
            if (grant_c[i]) begin
              slot_state[i] <= EMPTY;
            end
          end
          default: slot_state[i] <= EMPTY;
        endcase
      end
      if (drain) begin
        rr_ptr <= next_ptr;
      end
      if (collide_hit) begin
        collide_q <= 1'b1;
      end
    end
  end

  // The reset term forces the write port quiet while reset is held, even if the CPU drives it.
  assign bus.hw_ready    = ~full_vec;
  assign bus.pending     = full_vec;
  assign bus.grant       = reset ? grant_c : '0;
  assign bus.rf_we       = reset & (bus.cpu_we | drain);
  assign bus.rf_rd       = !reset ? '0 : (bus.cpu_we ? bus.cpu_rd : win_rd);
  assign bus.rf_data     = !reset ? '0 : (bus.cpu_we ? bus.cpu_data : win_data);
  assign bus.cpu_collide = collide_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: slot writes are predicted into a
// scoreboard queue and matched by a negedge monitor as grants appear.
module tb_regfile_write_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    int          idx;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;

  regfile_write_arbiter_if #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) bus ();

  regfile_write_arbiter #(.NUM_REQ(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.hw_valid[i]        = v;
    bus.hw_rd[i*5 +: 5]    = rd;
    bus.hw_data[i*32 +: 32] = d;
  endtask

  task automatic set_cpu(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.cpu_we   = we;
    bus.cpu_rd   = rd;
    bus.cpu_data = d;
  endtask

  task automatic push_exp(input int i, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.idx  = i;
    e.rd   = rd;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every slot write must match the next predicted entry; otherwise the port follows the CPU.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.grant != 4'b0000) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("[TB] FAIL sb_unexpected: grant=%b with no write predicted", bus.grant);
        end
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          total++;
          assert ({bus.rf_we, bus.grant, bus.rf_rd, bus.rf_data} ===
                  {1'b1, 4'(4'b0001 << mon_exp.idx), mon_exp.rd, mon_exp.data}) else begin
            bad++;
            $error("[TB] FAIL sb_write: got we=%b grant=%b rd=%0d data=%0h want grant=%b rd=%0d data=%0h",
                   bus.rf_we, bus.grant, bus.rf_rd, bus.rf_data,
                   4'(4'b0001 << mon_exp.idx), mon_exp.rd, mon_exp.data);
          end
        end
      end else begin
        total++;
        assert (bus.rf_we === bus.cpu_we) else begin
          bad++;
          $error("[TB] FAIL rf_we_idle: got %b want %b", bus.rf_we, bus.cpu_we);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.hw_valid = '0;
    bus.hw_rd    = '0;
    bus.hw_data  = '0;
    set_cpu(1'b0, 5'd0, 32'd0);

    // Reset state
    #2;
    check_output("rst_ready", 64'(bus.hw_ready), 64'hF);
    check_output("rst_pending", 64'(bus.pending), 64'h0);
    check_output("rst_grant", 64'(bus.grant), 64'h0);
    check_output("rst_rf", {31'd0, bus.rf_we, 27'd0, bus.rf_rd}, 64'h0);
    check_output("rst_rf_data", 64'(bus.rf_data), 64'h0);
    check_output("rst_collide", 64'(bus.cpu_collide), 64'h0);
    #10;
    reset = 1'b1;
    tick();
    check_output("idle_ready", 64'(bus.hw_ready), 64'hF);
    check_output("idle_rf_we", 64'(bus.rf_we), 64'h0);

    // Single request: req1 -> r30
    $display("[TB] single request");
    apply_stimulus(1, 1'b1, 5'd30, 32'd3);
    push_exp(1, 5'd30, 32'd3);
    tick();
    apply_stimulus(1, 1'b0, 5'd0, 32'd0);
    check_output("single_pending", 64'(bus.pending), 64'h2);
    check_output("single_ready", 64'(bus.hw_ready), 64'hD);
    check_output("single_grant", 64'(bus.grant), 64'h2);
    check_output("single_rf", {bus.rf_we, 27'd0, bus.rf_rd, bus.rf_data}, {1'b1, 27'd0, 5'd30, 32'd3});
    tick();
    check_output("single_drained", 64'(bus.pending), 64'h0);
    check_output("single_ready_back", 64'(bus.hw_ready), 64'hF);

    // Round-robin from rr_ptr=2 over slots 0,2,3
    $display("[TB] round robin");
    apply_stimulus(0, 1'b1, 5'd10, 32'h100);
    apply_stimulus(2, 1'b1, 5'd12, 32'h200);
    apply_stimulus(3, 1'b1, 5'd13, 32'h300);
    push_exp(2, 5'd12, 32'h200);
    push_exp(3, 5'd13, 32'h300);
    push_exp(0, 5'd10, 32'h100);
    tick();
    apply_stimulus(0, 1'b0, 5'd0, 32'd0);
    apply_stimulus(2, 1'b0, 5'd0, 32'd0);
    apply_stimulus(3, 1'b0, 5'd0, 32'd0);
    check_output("rr_pending", 64'(bus.pending), 64'hD);
    check_output("rr_grant0", 64'(bus.grant), 64'h4);
    tick();
    check_output("rr_grant1", 64'(bus.grant), 64'h8);
    tick();
    check_output("rr_grant2", 64'(bus.grant), 64'h1);
    tick();
    check_output("rr_empty", 64'(bus.pending), 64'h0);

    // CPU priority and collision on r30
    $display("[TB] cpu priority");
    apply_stimulus(0, 1'b1, 5'd30, 32'hAAAA);
    push_exp(0, 5'd30, 32'hAAAA);
    set_cpu(1'b1, 5'd30, 32'h55);
    tick();
    apply_stimulus(0, 1'b0, 5'd0, 32'd0);
    check_output("cpu_pending", 64'(bus.pending), 64'h1);
    check_output("cpu_collide_pre", 64'(bus.cpu_collide), 64'h0);
    for (int n = 0; n < 4; n++) begin
      check_output("cpu_grant", 64'(bus.grant), 64'h0);
      check_output("cpu_rf", {bus.rf_we, 27'd0, bus.rf_rd, bus.rf_data}, {1'b1, 27'd0, 5'd30, 32'h55});
      tick();
      check_output("cpu_collide", 64'(bus.cpu_collide), 64'h1);
    end
    set_cpu(1'b0, 5'd0, 32'd0);
    #1;
    check_output("cpu_release_grant", 64'(bus.grant), 64'h1);
    check_output("cpu_release_rf", {bus.rf_we, 27'd0, bus.rf_rd, bus.rf_data}, {1'b1, 27'd0, 5'd30, 32'hAAAA});
    tick();
    check_output("cpu_release_empty", 64'(bus.pending), 64'h0);
    check_output("cpu_collide_sticky", 64'(bus.cpu_collide), 64'h1);

    // Zero-register discard and held valid while full
    $display("[TB] zero register and held valid");
    apply_stimulus(2, 1'b1, 5'd0, 32'd7);
    apply_stimulus(0, 1'b1, 5'd5, 32'h77);
    push_exp(0, 5'd5, 32'h77);
    tick();
    apply_stimulus(2, 1'b0, 5'd0, 32'd0);
    set_cpu(1'b1, 5'd1, 32'h11);
    check_output("zero_pending", 64'(bus.pending), 64'h1);
    check_output("zero_ready", 64'(bus.hw_ready), 64'hE);
    tick();
    tick();
    check_output("held_pending", 64'(bus.pending), 64'h1);
    check_output("held_ready", 64'(bus.hw_ready), 64'hE);
    apply_stimulus(0, 1'b0, 5'd0, 32'd0);
    set_cpu(1'b0, 5'd0, 32'd0);
    #1;
    check_output("held_grant", 64'(bus.grant), 64'h1);
    tick();
    check_output("held_drained", 64'(bus.pending), 64'h0);

    // Reset mid-operation drops full slots
    $display("[TB] reset mid operation");
    apply_stimulus(1, 1'b1, 5'd7, 32'd1);
    apply_stimulus(3, 1'b1, 5'd8, 32'd2);
    set_cpu(1'b1, 5'd2, 32'h22);
    tick();
    apply_stimulus(1, 1'b0, 5'd0, 32'd0);
    apply_stimulus(3, 1'b0, 5'd0, 32'd0);
    check_output("mid_pending", 64'(bus.pending), 64'hA);
    set_cpu(1'b0, 5'd0, 32'd0);
    #1;
    check_output("mid_rf_we_before", 64'(bus.rf_we), 64'h1);
    reset = 1'b0;
    #1;
    check_output("mid_rf_we", 64'(bus.rf_we), 64'h0);
    check_output("mid_pending_clr", 64'(bus.pending), 64'h0);
    check_output("mid_grant", 64'(bus.grant), 64'h0);
    check_output("mid_collide_clr", 64'(bus.cpu_collide), 64'h0);
    tick();
    #2;
    reset = 1'b1;
    tick();
    tick();
    check_output("post_pending", 64'(bus.pending), 64'h0);
    check_output("post_rf_we", 64'(bus.rf_we), 64'h0);
    check_output("sb_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
